// File: rtl/store_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_buf_pkg
//  Description : Shared definitions for the post-MEM store buffer:
//                load/store instruction ids and lane-formatting helpers.
//                  store_strb     - byte strobes of a store at an address
//                  load_mask      - bytes read by a load at an address
//                  lane_replicate - store data replicated across lanes
//  Revision    : 1.0 - initial release
// ============================================================================
package store_buf_pkg;

  localparam logic [5:0] LB  = 6'd8;
  localparam logic [5:0] LH  = 6'd9;
  localparam logic [5:0] LW  = 6'd10;
  localparam logic [5:0] LBU = 6'd11;
  localparam logic [5:0] LHU = 6'd12;
  localparam logic [5:0] SB  = 6'd13;
  localparam logic [5:0] SH  = 6'd14;
  localparam logic [5:0] SW  = 6'd15;

  function automatic logic is_store(input logic [5:0] id);
    return (id == SB) || (id == SH) || (id == SW);
  endfunction

  function automatic logic is_load(input logic [5:0] id);
    return (id >= LB) && (id <= LHU);
  endfunction

  function automatic logic [3:0] store_strb(input logic [5:0] id, input logic [1:0] a);
    case (id)
      SB:      return 4'b0001 << a;
      SH:      return 4'b0011 << {a[1], 1'b0};
      SW:      return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] load_mask(input logic [5:0] id, input logic [1:0] a);
    case (id)
      LB, LBU: return 4'b0001 << a;
      LH, LHU: return 4'b0011 << {a[1], 1'b0};
      LW:      return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [5:0] id, input logic [31:0] d);
    case (id)
      SB:      return {4{d[7:0]}};
      SH:      return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_buf_match.sv
`default_nettype none
// ============================================================================
//  Module      : store_buf_match
//  Description : Age-ordered load lookup across all buffered stores. Walks
//                entries from head (oldest) toward tail (youngest); the last
//                matching entry in that walk is the youngest match.
//  Ports       : i_lookup_en  - a valid load is being looked up
//                i_ld_word    - load word address (addr[31:2])
//                i_ld_mask    - bytes the load reads
//                i_head       - oldest entry index
//                i_valid/i_addr/i_strb/i_data - entry arrays
//                o_hit        - youngest match covers every load byte
//                o_partial    - youngest match covers only some load bytes
//                o_data       - data of youngest match when o_hit, else 0
//  Revision    : 1.0 - initial release
// ============================================================================
module store_buf_match
  import store_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                    i_lookup_en,
  input  logic [29:0]             i_ld_word,
  input  logic [3:0]              i_ld_mask,
  input  logic [PTR_W-1:0]        i_head,
  input  logic [DEPTH-1:0]        i_valid,
  input  logic [DEPTH-1:0][29:0]  i_addr,
  input  logic [DEPTH-1:0][3:0]   i_strb,
  input  logic [DEPTH-1:0][31:0]  i_data,
  output logic                    o_hit,
  output logic                    o_partial,
  output logic [31:0]             o_data
);

  logic [PTR_W-1:0] w_age_idx [DEPTH];
  logic [DEPTH-1:0] w_match;
  logic             w_any;
  logic [3:0]       w_sel_strb;
  logic [31:0]      w_sel_data;
  logic             w_covered;

  // Age k maps to physical slot head+k; pointer width makes the wrap free.
  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    assign w_age_idx[g] = i_head + PTR_W'(g);
    assign w_match[g]   = i_valid[w_age_idx[g]]
                       && (i_addr[w_age_idx[g]] == i_ld_word)
                       && ((i_strb[w_age_idx[g]] & i_ld_mask) != 4'b0000);
  end

  always_comb begin
    w_any      = 1'b0;
    w_sel_strb = 4'b0000;
    w_sel_data = 32'h0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_match[k]) begin
        w_any      = 1'b1;
        w_sel_strb = i_strb[w_age_idx[k]];
        w_sel_data = i_data[w_age_idx[k]];
      end
    end
  end

  assign w_covered = ((w_sel_strb & i_ld_mask) == i_ld_mask);
  assign o_hit     = i_lookup_en && w_any && w_covered;
  assign o_partial = i_lookup_en && w_any && !w_covered;
  assign o_data    = o_hit ? w_sel_data : 32'h0;

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : Post-MEM write buffer. Holds committed SB/SH/SW stores in
//                FIFO order, drains them to data memory over a valid/ready
//                port and answers load lookups against buffered stores.
//                Optional macro STORE_BUF_COALESCE_EN merges a store into
//                the youngest (non-head) entry when word addresses match.
//  Ports       : clk, rst_n (async, active-low)
//                i_enq_*     - store from MEM stage, o_enq_ready back-pressure
//                o_mem_wr_*  - head entry toward memory, i_mem_wr_ready
//                i_ld_*      - load lookup; o_ld_hit/o_ld_data/o_ld_stall
//                o_count     - occupied entries, o_empty when zero
//  Revision    : 1.0 - initial release
// ============================================================================
module store_buffer
  import store_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enq_valid,
  output logic             o_enq_ready,
  input  logic [5:0]       i_enq_instr_id,
  input  logic [31:0]      i_enq_addr,
  input  logic [31:0]      i_enq_data,
  output logic             o_mem_wr_valid,
  input  logic             i_mem_wr_ready,
  output logic [31:0]      o_mem_wr_addr,
  output logic [31:0]      o_mem_wr_data,
  output logic [3:0]       o_mem_wr_strb,
  input  logic             i_ld_valid,
  input  logic [5:0]       i_ld_instr_id,
  input  logic [31:0]      i_ld_addr,
  output logic             o_ld_hit,
  output logic [31:0]      o_ld_data,
  output logic             o_ld_stall,
  output logic [PTR_W:0]   o_count,
  output logic             o_empty
);

  localparam logic [PTR_W:0] c_full = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]        r_head;
  logic [PTR_W-1:0]        r_tail;
  logic [PTR_W:0]          r_count;
  logic [DEPTH-1:0]        r_valid;
  logic [DEPTH-1:0][29:0]  r_addr;
  logic [DEPTH-1:0][3:0]   r_strb;
  logic [DEPTH-1:0][31:0]  r_data;

  logic        w_is_store;
  logic [3:0]  w_enq_strb;
  logic [31:0] w_enq_data;
  logic        w_enq_fire;
  logic        w_alloc;
  logic        w_pop;
  logic        w_nonempty;
  logic        w_lookup_en;
  logic [3:0]  w_ld_mask;

  assign w_is_store = is_store(i_enq_instr_id);
  assign w_enq_strb = store_strb(i_enq_instr_id, i_enq_addr[1:0]);
  assign w_enq_data = lane_replicate(i_enq_instr_id, i_enq_data);
  assign w_nonempty = (r_count != '0);
  assign w_pop      = w_nonempty && i_mem_wr_ready;
  assign w_enq_fire = i_enq_valid && o_enq_ready && w_is_store;

`ifdef STORE_BUF_COALESCE_EN
  logic [PTR_W-1:0] w_young;
  logic             w_merge_cand;
  logic             w_merge;

  // Merge only into a youngest entry that is not the head, so it can never
  // be the entry popping this cycle.
  assign w_young      = r_tail - 1'b1;
  assign w_merge_cand = w_is_store
                     && (r_count >= (PTR_W+1)'(2))
                     && (r_addr[w_young] == i_enq_addr[31:2]);
  assign w_merge      = w_enq_fire && w_merge_cand;
  assign o_enq_ready  = (r_count != c_full) || w_merge_cand;
  assign w_alloc      = w_enq_fire && !w_merge_cand;
`else
  // No full bypass: a pop in the same cycle does not open the slot early.
  assign o_enq_ready  = (r_count != c_full);
  assign w_alloc      = w_enq_fire;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_addr  <= '0;
      r_strb  <= '0;
      r_data  <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= i_enq_addr[31:2];
        r_strb[r_tail]  <= w_enq_strb;
        r_data[r_tail]  <= w_enq_data;
        r_tail          <= r_tail + 1'b1;
      end
`ifdef STORE_BUF_COALESCE_EN
      if (w_merge) begin
        r_strb[w_young] <= r_strb[w_young] | w_enq_strb;
        for (int b = 0; b < 4; b++) begin
          if (w_enq_strb[b]) begin
            r_data[w_young][8*b +: 8] <= w_enq_data[8*b +: 8];
          end
        end
      end
`endif
      r_count <= r_count + (PTR_W+1)'(w_alloc) - (PTR_W+1)'(w_pop);
    end
  end

  // Head entry toward memory; forced to zero while empty so stale slots
  // never leak onto the bus.
  assign o_mem_wr_valid = w_nonempty;
  assign o_mem_wr_addr  = w_nonempty ? {r_addr[r_head], 2'b00} : 32'h0;
  assign o_mem_wr_data  = w_nonempty ? r_data[r_head] : 32'h0;
  assign o_mem_wr_strb  = w_nonempty ? r_strb[r_head] : 4'b0000;
  assign o_count        = r_count;
  assign o_empty        = !w_nonempty;

  assign w_lookup_en = i_ld_valid && is_load(i_ld_instr_id);
  assign w_ld_mask   = load_mask(i_ld_instr_id, i_ld_addr[1:0]);

  store_buf_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_match (
    .i_lookup_en (w_lookup_en),
    .i_ld_word   (i_ld_addr[31:2]),
    .i_ld_mask   (w_ld_mask),
    .i_head      (r_head),
    .i_valid     (r_valid),
    .i_addr      (r_addr),
    .i_strb      (r_strb),
    .i_data      (r_data),
    .o_hit       (o_ld_hit),
    .o_partial   (o_ld_stall),
    .o_data      (o_ld_data)
  );

endmodule
`default_nettype wire

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Post-MEM write buffer. Holds committed stores (SB/SH/SW) in FIFO order and drains them to data memory through a valid/ready write port.
- Serves load lookups against all buffered stores. A load returns store data when one entry fully covers it, and requests a stall when coverage is only partial.
- Sits between the MEM stage and the data-memory write interface. It is the store-side producer that the load forwarding path consumes.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2
- PTR_W, $clog2(DEPTH), pointer width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enq_valid  in  1  store presented by MEM stage
- enq_ready  out  1  buffer can accept a store
- enq_instr_id  in  6  instruction id: SB=13, SH=14, SW=15
- enq_addr  in  32  store byte address
- enq_data  in  32  store source data, right-aligned
- mem_wr_valid  out  1  head entry valid toward memory
- mem_wr_ready  in  1  memory accepts write
- mem_wr_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wr_data  out  32  lane-aligned write data
- mem_wr_strb  out  4  byte strobes
- ld_valid  in  1  load lookup request
- ld_instr_id  in  6  LB=8, LH=9, LW=10, LBU=11, LHU=12
- ld_addr  in  32  load byte address
- ld_hit  out  1  youngest match fully covers load bytes
- ld_data  out  32  lane-aligned word from the matching entry (extension done downstream)
- ld_stall  out  1  youngest match only partially covers load
- count  out  PTR_W+1  occupied entries
- empty  out  1  count==0

Behaviour:
- Reset (async, rst_n=0): head=tail=0, count=0, all entry valid bits 0. Resulting outputs: enq_ready=1, mem_wr_valid=0, ld_hit=0, ld_stall=0, ld_data=0, empty=1. The strobe/data/addr outputs are 0 while empty. Reset mid-drain discards all entries with no write completion.
- Enqueue:
  - Fires when enq_valid && enq_ready; enq_ready = (count!=DEPTH).
  - Entry written at tail; tail increments mod DEPTH.
  - A non-store enq_instr_id with enq_valid=1 is ignored and not stored.
- Lane formatting at enqueue:
  - SB: strb=4'b0001<<addr[1:0], data byte replicated to all lanes.
  - SH: strb=4'b0011<<{addr[1],1'b0}, halfword replicated.
  - SW: strb=4'b1111.
  - Misaligned SH/SW is not checked (trap handled upstream); use addr[1:0] as given.
- Drain:
  - mem_wr_valid = !empty; mem_wr_* driven combinationally from head.
  - Pop when mem_wr_valid && mem_wr_ready; head increments mod DEPTH.
  - Outputs must hold stable while valid && !ready.
- Simultaneous enq+pop: count unchanged. When full, enq_ready=0 even if a pop occurs that cycle (no full bypass); the freed slot is visible next cycle.
- Lookup (combinational on registered state):
  - Load byte mask is derived like the store strobes: LB/LBU 1 byte, LH/LHU 2 bytes, LW 4 bytes.
  - Match = valid entry with addr[31:2]==ld_addr[31:2] and (strb & ldmask)!=0. The youngest match (closest to tail) wins.
  - If youngest_strb covers ldmask: ld_hit=1, ld_data=entry data.
  - Else if any match exists: ld_stall=1, ld_hit=0.
  - With no match, or ld_valid=0: ld_hit=0, ld_stall=0, ld_data=0.
  - An entry popping this cycle still participates.
  - A store enqueuing this cycle is not visible; adjacent MEM-stage pairs are covered by the existing pipeline forwarding.
- Wrap-around: pointers wrap silently. "Youngest" is the order relative to head, not the physical index.

Optional Feature:
- Macro STORE_BUF_COALESCE_EN.
- Defined: an enqueue whose word address equals the youngest entry's, with count>=2 (youngest is not head), merges into that entry instead of allocating. Merge rule: strb|=new_strb; new bytes overwrite lanes. tail and count unchanged.
- Coalescing is also allowed when full: enq_ready=1 if the incoming store would merge. The merge condition is evaluated on registered state only.
- Not defined: every store allocates a new entry.

Decomposition:
- Package store_buf_pkg: instruction-id localparams LB..LHU (8..12) and SB..SW (13..15), plus functions store_strb(id,addr), load_mask(id,addr), and lane_replicate(id,data).
- Sub-module store_buf_match: age-ordered address compare and youngest-match priority select. Inputs: entry arrays, head, and load word/mask. Outputs: hit, partial, and selected data.

Test Plan:
- Reset, then SW 0x100 data 0xDEADBEEF with mem_wr_ready=0 -> count=1, mem_wr_valid=1, addr 0x100, strb 4'hF, data held stable; raise ready -> pop next cycle, empty=1.
- SB 0x103 data 0x000000AA, then LBU 0x103 -> ld_hit=1, ld_data=0xAAAAAAAA, strb 4'b1000.
- SB 0x200, then LW 0x200 -> ld_stall=1, ld_hit=0. Then SW 0x200 0x11223344 -> LW hit with 0x11223344 (youngest wins).
- Hold mem_wr_ready=0 and enqueue DEPTH+1 stores -> enq_ready=0 at count=4. Pop and enqueue in the same cycle -> enq not accepted that cycle, accepted next. Pointers wrap and FIFO order is preserved.
- Assert rst_n low mid-stream with 3 entries -> all outputs return to reset values immediately; the pending load lookup gives no hit.
- With STORE_BUF_COALESCE_EN: SW 0x300, SB 0x304 0x55, SB 0x305 0x66 -> count=2; second entry strb 4'b0011, data lanes 0x6655.
